// File: rtl/display_msg_scheduler.sv
// Fixed-priority scheduler sharing an 8-digit seven-segment display between message sources.
// Each captured message is shown for DWELL_CYCLES. An optional higher-priority preemption is supported.
module display_msg_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int DWELL_CYCLES = 100000000,
   parameter int CNT_W        = 27,
   parameter int PREEMPT      = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*40-1:0] msg_in,
   input  logic [39:0]           idle_msg,
   output logic [39:0]           instruction,
   output logic [NUM_REQ-1:0]    grant,
   output logic                  busy,
   output logic [NUM_REQ-1:0]    ack,
   output logic [NUM_REQ-1:0]    overflow
);

   localparam int               IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [0:0]       ST_IDLE   = 1'b0;
   localparam logic [0:0]       ST_SHOW   = 1'b1;
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [NUM_REQ-1:0] REQ_ZERO = NUM_REQ'(0);
   localparam logic [NUM_REQ-1:0] REQ_ONE  = NUM_REQ'(1);

   logic [0:0]         state_r;
   logic [NUM_REQ-1:0] pending_r;
   logic [39:0]        msg_buf_r [NUM_REQ];
   logic [CNT_W-1:0]   cnt_r;
   logic [IDX_W-1:0]   gidx_r;
   logic [NUM_REQ-1:0] grant_r;
   logic [NUM_REQ-1:0] ack_r;
   logic [NUM_REQ-1:0] overflow_r;
   logic               busy_r;
   logic [39:0]        instruction_r;

   logic [IDX_W-1:0]   winner_s;
   logic               any_pend_s;
   logic               complete_s;
   logic               preempt_s;
   logic [NUM_REQ-1:0] clear_s;
   logic [NUM_REQ-1:0] pending_nxt_s;
   logic [NUM_REQ-1:0] overflow_s;

   // Lowest-index pending source wins; scanned downward so the last hit is the highest priority.
   always_comb begin
      winner_s   = IDX_W'(0);
      any_pend_s = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (pending_r[i]) begin
            winner_s   = IDX_W'(i);
            any_pend_s = 1'b1;
         end else begin
            winner_s   = winner_s;
         end
      end
   end

   // Completion, preemption and the next pending vector (a recapture beats a clear).
   always_comb begin
      complete_s    = (state_r == ST_SHOW) && (cnt_r == CNT_ZERO);
      preempt_s     = (PREEMPT != 0) && (state_r == ST_SHOW) && (cnt_r != CNT_ZERO)
                      && any_pend_s && (winner_s < gidx_r);
      clear_s       = complete_s ? grant_r : REQ_ZERO;
      pending_nxt_s = (pending_r & ~clear_s) | req;
      overflow_s    = req & pending_r & ~clear_s;
   end

   // Message capture, pending bookkeeping and the one-cycle ack/overflow pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r  <= REQ_ZERO;
         ack_r      <= REQ_ZERO;
         overflow_r <= REQ_ZERO;
         for (int i = 0; i < NUM_REQ; i++) begin
            msg_buf_r[i] <= 40'd0;
         end
      end else begin
         pending_r  <= pending_nxt_s;
         ack_r      <= clear_s;
         overflow_r <= overflow_s;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
               msg_buf_r[i] <= msg_in[40*i +: 40];
            end else begin
               msg_buf_r[i] <= msg_buf_r[i];
            end
         end
      end
   end

   // Display FSM: the completion edge always returns to IDLE, which gives the one-cycle idle gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         cnt_r         <= CNT_ZERO;
         gidx_r        <= IDX_W'(0);
         grant_r       <= REQ_ZERO;
         busy_r        <= 1'b0;
         instruction_r <= 40'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_pend_s) begin
                  state_r       <= ST_SHOW;
                  cnt_r         <= CNT_LOAD;
                  gidx_r        <= winner_s;
                  grant_r       <= REQ_ONE << winner_s;
                  busy_r        <= 1'b1;
                  instruction_r <= msg_buf_r[winner_s];
               end else begin
                  cnt_r         <= CNT_ZERO;
                  grant_r       <= REQ_ZERO;
                  busy_r        <= 1'b0;
                  instruction_r <= idle_msg;
               end
            end
            ST_SHOW: begin
               if (complete_s) begin
                  state_r       <= ST_IDLE;
                  cnt_r         <= CNT_ZERO;
                  grant_r       <= REQ_ZERO;
                  busy_r        <= 1'b0;
                  instruction_r <= idle_msg;
               end else if (preempt_s) begin
                  cnt_r         <= CNT_LOAD;
                  gidx_r        <= winner_s;
                  grant_r       <= REQ_ONE << winner_s;
                  instruction_r <= msg_buf_r[winner_s];
               end else begin
                  cnt_r         <= cnt_r - CNT_ONE;
                  instruction_r <= msg_buf_r[gidx_r];
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               cnt_r         <= CNT_ZERO;
               grant_r       <= REQ_ZERO;
               busy_r        <= 1'b0;
               instruction_r <= 40'd0;
            end
         endcase
      end
   end

   assign instruction = instruction_r;
   assign grant       = grant_r;
   assign busy        = busy_r;
   assign ack         = ack_r;
   assign overflow    = overflow_r;

   display_msg_scheduler_chk #(
      .NUM_REQ      (NUM_REQ),
      .DWELL_CYCLES (DWELL_CYCLES),
      .CNT_W        (CNT_W)
   ) u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt   (cnt_r),
      .grant (grant_r)
   );

endmodule

// Simulation checks on the parameters and on the counter and grant invariants.
module display_msg_scheduler_chk #(
   parameter int NUM_REQ      = 4,
   parameter int DWELL_CYCLES = 100000000,
   parameter int CNT_W        = 27
) (
   input logic               clk,
   input logic               rst_n,
   input logic [CNT_W-1:0]   cnt,
   input logic [NUM_REQ-1:0] grant
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

   // Dwell must be at least 2 cycles, must fit the counter, and at most one source may be granted.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (DWELL_CYCLES >= 2) else $error("DWELL_CYCLES below 2");
         assert (longint'(DWELL_CYCLES) < (longint'(1) << CNT_W)) else $error("CNT_W too narrow");
         assert (cnt <= CNT_LOAD) else $error("dwell counter out of range");
         assert ($onehot0(grant)) else $error("grant not one-hot");
      end else begin
      end
   end

endmodule

// File: tb/tb_display_msg_scheduler.sv
// Directed bench for display_msg_scheduler with DWELL_CYCLES=8, NUM_REQ=4, PREEMPT=1.
module tb_display_msg_scheduler;

   localparam logic [39:0] IDLE = 40'h12345_6789A;
   localparam logic [39:0] M0   = 40'h0F0F0_F0F0F;
   localparam logic [39:0] M1   = 40'h11111_11111;
   localparam logic [39:0] M2   = 40'hAAAAA_AAAAA;
   localparam logic [39:0] M3   = 40'h33333_33333;
   localparam logic [39:0] M6   = 40'h66666_66666;
   localparam logic [39:0] M7   = 40'h77777_77777;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req;
   logic [159:0] msg_in;
   logic [39:0]  idle_msg;
   logic [39:0]  instruction;
   logic [3:0]   grant;
   logic         busy;
   logic [3:0]   ack;
   logic [3:0]   overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   display_msg_scheduler #(
      .NUM_REQ(4), .DWELL_CYCLES(8), .CNT_W(4), .PREEMPT(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .msg_in(msg_in), .idle_msg(idle_msg),
      .instruction(instruction), .grant(grant), .busy(busy), .ack(ack), .overflow(overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; req = 4'd0; msg_in = 160'd0; idle_msg = IDLE;
      #1 rst_n = 1'b0;
      #20;
      checks++;
      if ({instruction, grant, busy, ack, overflow} !== {40'd0, 4'd0, 1'b0, 4'd0, 4'd0}) begin
         failures++;
         $display("FAIL reset_state got=%h/%b/%b exp=0/0/0", instruction, grant, busy);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if ({instruction, grant, busy} !== {IDLE, 4'd0, 1'b0}) begin
         failures++;
         $display("FAIL idle_follow got=%h exp=%h", instruction, IDLE);
      end
      idle_msg = 40'hFEDCB_A9876;
      tick();
      checks++;
      if (instruction !== 40'hFEDCB_A9876) begin
         failures++;
         $display("FAIL idle_track got=%h exp=%h", instruction, 40'hFEDCB_A9876);
      end
      idle_msg = IDLE;
      tick();
   endtask

   task automatic test_single();
      req = 4'b0100; msg_in[80 +: 40] = M2;
      tick();
      req = 4'd0;
      checks++;
      if ({grant, busy, instruction} !== {4'd0, 1'b0, IDLE}) begin
         failures++;
         $display("FAIL single_latency got=%b %h exp=0000 %h", grant, instruction, IDLE);
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if ({grant, busy, ack, instruction} !== {4'b0100, 1'b1, 4'd0, M2}) begin
            failures++;
            $display("FAIL single_show cyc=%0d got=%b %b %h exp=0100 0000 %h", c, grant, ack, instruction, M2);
         end
      end
      tick();
      checks++;
      if ({grant, busy, ack, instruction} !== {4'd0, 1'b0, 4'b0100, IDLE}) begin
         failures++;
         $display("FAIL single_ack got=%b %b %h exp=0000 0100 %h", grant, ack, instruction, IDLE);
      end
      tick();
      checks++;
      if ({grant, ack, instruction} !== {4'd0, 4'd0, IDLE}) begin
         failures++;
         $display("FAIL single_after got=%b %b %h exp=0000 0000 %h", grant, ack, instruction, IDLE);
      end
   endtask

   task automatic test_priority();
      req = 4'b1010; msg_in[40 +: 40] = M1; msg_in[120 +: 40] = M3;
      tick();
      req = 4'd0;
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if ({grant, ack, instruction} !== {4'b0010, 4'd0, M1}) begin
            failures++;
            $display("FAIL prio_first cyc=%0d got=%b %b %h exp=0010 0000 %h", c, grant, ack, instruction, M1);
         end
      end
      tick();
      checks++;
      if ({grant, busy, ack, instruction} !== {4'd0, 1'b0, 4'b0010, IDLE}) begin
         failures++;
         $display("FAIL prio_gap got=%b %b %h exp=0000 0010 %h", grant, ack, instruction, IDLE);
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if ({grant, ack, instruction} !== {4'b1000, 4'd0, M3}) begin
            failures++;
            $display("FAIL prio_second cyc=%0d got=%b %b %h exp=1000 0000 %h", c, grant, ack, instruction, M3);
         end
      end
      tick();
      checks++;
      if ({grant, ack, instruction} !== {4'd0, 4'b1000, IDLE}) begin
         failures++;
         $display("FAIL prio_ack3 got=%b %b %h exp=0000 1000 %h", grant, ack, instruction, IDLE);
      end
      tick();
   endtask

   task automatic test_preempt();
      req = 4'b0100; msg_in[80 +: 40] = M2;
      tick();
      req = 4'd0;
      tick();
      tick();
      req = 4'b0001; msg_in[0 +: 40] = M0;
      tick();
      req = 4'd0;
      checks++;
      if ({grant, ack, instruction} !== {4'b0100, 4'd0, M2}) begin
         failures++;
         $display("FAIL preempt_before got=%b %b %h exp=0100 0000 %h", grant, ack, instruction, M2);
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if ({grant, busy, ack, instruction} !== {4'b0001, 1'b1, 4'd0, M0}) begin
            failures++;
            $display("FAIL preempt_show cyc=%0d got=%b %b %h exp=0001 0000 %h", c, grant, ack, instruction, M0);
         end
      end
      tick();
      checks++;
      if ({grant, ack, instruction} !== {4'd0, 4'b0001, IDLE}) begin
         failures++;
         $display("FAIL preempt_ack0 got=%b %b %h exp=0000 0001 %h", grant, ack, instruction, IDLE);
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if ({grant, ack, instruction} !== {4'b0100, 4'd0, M2}) begin
            failures++;
            $display("FAIL preempt_reshow cyc=%0d got=%b %b %h exp=0100 0000 %h", c, grant, ack, instruction, M2);
         end
      end
      tick();
      checks++;
      if ({grant, ack, instruction} !== {4'd0, 4'b0100, IDLE}) begin
         failures++;
         $display("FAIL preempt_ack2 got=%b %b %h exp=0000 0100 %h", grant, ack, instruction, IDLE);
      end
      tick();
   endtask

   task automatic test_overflow();
      req = 4'b0001; msg_in[0 +: 40] = M0;
      tick();
      req = 4'd0;
      tick();
      req = 4'b0010; msg_in[40 +: 40] = M1;
      tick();
      checks++;
      if (overflow !== 4'd0) begin
         failures++;
         $display("FAIL ovf_first got=%b exp=0000", overflow);
      end
      msg_in[40 +: 40] = M6;
      tick();
      req = 4'd0;
      checks++;
      if (overflow !== 4'b0010) begin
         failures++;
         $display("FAIL ovf_pulse got=%b exp=0010", overflow);
      end
      tick();
      checks++;
      if ({overflow, grant, instruction} !== {4'd0, 4'b0001, M0}) begin
         failures++;
         $display("FAIL ovf_clear got=%b %b %h exp=0000 0001 %h", overflow, grant, instruction, M0);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
      end
      tick();
      checks++;
      if ({grant, ack, instruction} !== {4'd0, 4'b0001, IDLE}) begin
         failures++;
         $display("FAIL ovf_ack0 got=%b %b %h exp=0000 0001 %h", grant, ack, instruction, IDLE);
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if ({grant, ack, instruction} !== {4'b0010, 4'd0, M6}) begin
            failures++;
            $display("FAIL ovf_latest cyc=%0d got=%b %b %h exp=0010 0000 %h", c, grant, ack, instruction, M6);
         end
      end
      req = 4'b0010; msg_in[40 +: 40] = M7;
      tick();
      req = 4'd0;
      checks++;
      if ({grant, ack, overflow, instruction} !== {4'd0, 4'b0010, 4'd0, IDLE}) begin
         failures++;
         $display("FAIL complete_edge_req got=%b %b %b %h exp=0000 0010 0000 %h", grant, ack, overflow, instruction, IDLE);
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if ({grant, ack, instruction} !== {4'b0010, 4'd0, M7}) begin
            failures++;
            $display("FAIL reshow_new cyc=%0d got=%b %b %h exp=0010 0000 %h", c, grant, ack, instruction, M7);
         end
      end
      tick();
      checks++;
      if ({grant, ack, instruction} !== {4'd0, 4'b0010, IDLE}) begin
         failures++;
         $display("FAIL reshow_ack got=%b %b %h exp=0000 0010 %h", grant, ack, instruction, IDLE);
      end
      tick();
   endtask

   task automatic test_async_reset();
      req = 4'b1100; msg_in[80 +: 40] = M2; msg_in[120 +: 40] = M3;
      tick();
      req = 4'd0;
      for (int c = 0; c < 4; c++) begin
         tick();
      end
      checks++;
      if ({grant, busy, instruction} !== {4'b0100, 1'b1, M2}) begin
         failures++;
         $display("FAIL arst_pre got=%b %b %h exp=0100 1 %h", grant, busy, instruction, M2);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({instruction, grant, busy, ack, overflow} !== {40'd0, 4'd0, 1'b0, 4'd0, 4'd0}) begin
         failures++;
         $display("FAIL arst_immediate got=%h %b %b exp=0 0000 0", instruction, grant, busy);
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         checks++;
         if ({grant, busy, ack, instruction} !== {4'd0, 1'b0, 4'd0, IDLE}) begin
            failures++;
            $display("FAIL arst_after cyc=%0d got=%b %b %b %h exp=0000 0 0000 %h", c, grant, busy, ack, instruction, IDLE);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_preempt();
      test_overflow();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/display_msg_scheduler.md
Name: display_msg_scheduler

Overview:
- Shares the 8-digit seven-segment display between NUM_REQ message sources (error, prompt, balance, status, etc.).
- Drives the display decoder's 40-bit instruction bus: 8 characters × 5-bit code, digit 0 in bits [4:0], code 0 = blank.
- Each request latches its message and shows it for a fixed dwell time, under fixed-priority arbitration with optional preemption.
- With nothing pending, the block shows a live idle message.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 is highest priority.
- DWELL_CYCLES, 100000000, clock cycles each message is shown; must be ≥ 2.
- CNT_W, 27, dwell counter width; must satisfy 2^CNT_W > DWELL_CYCLES.
- PREEMPT, 1, 1 = a higher-priority pending request aborts the message being shown.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-source request pulse; may be multi-cycle, every high cycle recaptures.
- msg_in  in  NUM_REQ*40  message for source i in bits [40*i+39:40*i]; sampled when req[i]=1.
- idle_msg  in  40  message shown while idle; passed through live, not latched.
- instruction  out  40  registered; to the display decoder.
- grant  out  NUM_REQ  registered, one-hot or zero; the source currently shown.
- busy  out  1  registered; 1 in SHOW.
- ack  out  NUM_REQ  one-cycle pulse when source i completes its full dwell.
- overflow  out  NUM_REQ  one-cycle pulse when req[i] overwrites a still-pending, not-yet-completed message.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - pending, msg buffers, counter, grant, ack, overflow all 0.
  - busy=0, instruction=40'd0 (all blank).
- Capture:
  - Edge with req[i]=1: buf[i]<=msg_in slice, pending[i]<=1.
  - If pending[i] was already 1 and not being cleared that edge: overflow[i]=1 for one cycle (latest message wins).
  - If source i is currently shown, its new message appears on instruction at the next edge. The dwell counter is not restarted.
- Arbitration: winner = lowest index with pending=1, evaluated from the registered pending vector.
- IDLE:
  - instruction<=idle_msg every edge; grant=0, busy=0.
  - If any pending: next edge goes to SHOW with grant<=onehot(winner), instruction<=buf[winner], counter<=DWELL_CYCLES-1, busy<=1.
  - Latency: req high at edge E, pending at E, instruction shows the message after edge E+1.
- SHOW:
  - instruction<=buf[granted] each edge; counter decrements each edge.
  - Completion (counter==0 at an edge):
    - ack[g]=1 for one cycle; pending[g]<=0; state IDLE; grant<=0.
    - If req[g]=1 on that same edge: pending[g] stays 1 with the new buffer; ack still pulses; no overflow.
  - Preemption (PREEMPT=1, counter!=0, some pending[j] with j<g):
    - Next edge: grant<=onehot(j), instruction<=buf[j], counter reloaded.
    - Preempted g stays pending, gets no ack, and later gets a full fresh dwell.
  - Completion and preemption on the same edge: completion wins. The next message follows via IDLE.
- Inter-message gap: exactly one IDLE cycle between consecutive messages, showing idle_msg.
- Simultaneous requests: all captured; served strictly in priority order.
- PREEMPT=0: the current message always completes its dwell.
- Reset mid-SHOW: immediate return to reset values; all pending messages are discarded with no ack.
- Counter width: the counter must never wrap; the DWELL_CYCLES ≥ 2 precondition is checked by assertion in simulation.

Test Plan:
- Parameters for all scenarios: DWELL_CYCLES=8, NUM_REQ=4.
- Reset/idle: rst_n=0 → instruction=0, grant=0, busy=0. Release with idle_msg=40'h12345_6789A → instruction follows idle_msg one edge later; changing idle_msg is tracked each edge.
- Single message: req[2] pulse with msg 40'hAAAAA_AAAAA at edge E → grant=4'b0100 and instruction=40'hAAAAA_AAAAA after E+1, held 8 cycles; ack[2] pulse; then idle_msg.
- Priority: req[3] and req[1] pulsed the same edge → source 1 shown for 8 cycles, ack[1], one idle cycle, source 3 shown for 8 cycles, ack[3].
- Preemption: source 2 shown, req[0] arrives at dwell cycle 3 → source 0 shown next edge for full 8 cycles, ack[0]; then source 2 re-shown for full 8 cycles, ack[2]. No ack[2] at the preemption point.
- Overflow/boundary: two req[1] pulses while source 0 is shown → one overflow[1] pulse and the second message is displayed. req[g] on the completion edge → ack[g] pulses and the new message is re-shown after one idle cycle.
- Async reset mid-SHOW: rst_n low at dwell cycle 4 → all outputs reset immediately without waiting for clk; after release, IDLE with nothing pending.
